dmem_latency_ctrl: RTL
======================

Name: dmem_latency_ctrl

Overview:
- Sequencer between the MEM stage of the 5-stage MIPS pipeline and the data memory RAM.
- Models a data memory with a configurable access latency.
- Holds each load/store for LATENCY cycles, issues exactly one RAM access, and raises a stall to the hazard unit until the result is ready.

Parameters:
LATENCY, 4, data memory access latency in cycles; legal range 0..15; 0 selects bypass mode.
AW, 32, byte address width from the ALU.
DW, 32, data width.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
CLR  input  1  reset; asynchronous, active-low.
MemReadM  input  1  MEM-stage load request.
MemWriteM  input  1  MEM-stage store request.
ALUOutM  input  AW  byte address of the access.
WriteDataM  input  DW  store data.
StallMem  output  1  to the hazard unit; freezes PC and IF/ID, ID/EX and EX/MEM; holds MEM/WB.
ReadDataM  output  DW  load result into MEM/WB.
ram_we  output  1  RAM write enable; the RAM writes on the rising edge when high.
ram_addr  output  AW-2  word index, ALUOutM[AW-1:2].
ram_wdata  output  DW  RAM write data.
ram_rdata  input  DW  RAM read data; asynchronous (combinational) read of ram_addr.

Behaviour:
- req = MemReadM | MemWriteM. If both are high, treat as a store.
- Reset (CLR low, any state, asynchronous):
  - state=IDLE, cnt=0, latched registers cleared.
  - StallMem=0, ReadDataM=0, ram_we=0, ram_addr=0, ram_wdata=0.
  - Any pending store is dropped; no RAM write occurs.
- States: IDLE, BUSY, DONE. Mode applies only when LATENCY>=1.
- IDLE:
  - StallMem = req, combinational, so the request cycle itself stalls.
  - On req: latch addr (ALUOutM[AW-1:2]), WriteDataM and is_store; cnt <= LATENCY-1; go BUSY.
  - ram_we=0.
- BUSY:
  - StallMem=1; ram_addr and ram_wdata driven from the latched values.
  - cnt != 0: cnt <= cnt-1.
  - cnt == 0, store: ram_we=1 this cycle only.
  - cnt == 0, load: rdata_q <= ram_rdata.
  - cnt == 0: go DONE.
- DONE:
  - StallMem=0 and ReadDataM=rdata_q; the pipeline advances at this edge.
  - Unconditional go IDLE; a request seen in DONE is the same instruction and is not re-issued.
- Stall timing: a request stalls exactly LATENCY+1 cycles, then one DONE cycle. Back-to-back memory instructions therefore cost LATENCY+2 cycles each.
- ReadDataM holds rdata_q in all states; it changes only at a load completion.
- Store completion leaves rdata_q unchanged.
- Inputs are ignored while BUSY; changes on MemReadM, MemWriteM, ALUOutM or WriteDataM have no effect.
- LATENCY=0 (bypass):
  - StallMem=0 permanently.
  - ram_addr, ram_wdata and ram_we = MemWriteM are driven combinationally from the inputs.
  - ReadDataM = ram_rdata combinationally. No state machine.
- cnt width is 4 bits. No wrap is possible, since the load value is at most 14.

Optional Feature:
- Macro DMEM_PERF_CNT_EN. When defined, adds two outputs:
  - stall_cycles[31:0]: increments every cycle StallMem=1.
  - access_cnt[31:0]: increments once per RAM access (BUSY with cnt==0, or in bypass each cycle with req).
- Both counters are cleared by CLR and saturate at 0xFFFFFFFF.
- When the macro is undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- LATENCY=4, RAM[32]=0x00001234, LW with ALUOutM=0x80 -> StallMem high 5 cycles; DONE cycle StallMem=0, ReadDataM=0x00001234.
- LATENCY=4, SW 0xDEADBEEF to 0x84, then LW 0x84 next instruction -> ram_we pulses once on the 5th stall cycle; LW returns 0xDEADBEEF after its own 5 stall cycles.
- LATENCY=4, SW 0xCAFEF00D to 0x88 (RAM[34] previously 0x11111111), CLR low in the 2nd BUSY cycle -> outputs go to 0 immediately; RAM[34] still 0x11111111; state IDLE after release.
- LATENCY=4, LW 0x80 whose ALUOutM changes to 0x90 mid-BUSY -> result is still RAM[32].
- LATENCY=0, LW 0x80 -> StallMem never high; ReadDataM=RAM[32] the same cycle.
- DMEM_PERF_CNT_EN, LATENCY=3, three LWs -> access_cnt=3, stall_cycles=12.

Source files
------------

// File: rtl/dmem_latency_ctrl_if.sv
// Bundle between the MEM stage, the latency sequencer and the data RAM.
// The master side is the pipeline plus RAM model. The slave side is the sequencer.
interface dmem_latency_ctrl_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          MemReadM;
  logic          MemWriteM;
  logic [AW-1:0] ALUOutM;
  logic [DW-1:0] WriteDataM;
  logic          StallMem;
  logic [DW-1:0] ReadDataM;
  logic          ram_we;
  logic [AW-3:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport master (
    output MemReadM, MemWriteM, ALUOutM, WriteDataM, ram_rdata,
    input  StallMem, ReadDataM, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  MemReadM, MemWriteM, ALUOutM, WriteDataM, ram_rdata,
    output StallMem, ReadDataM, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/dmem_latency_ctrl.sv
// Holds each MEM-stage access for LATENCY cycles, stalling the pipeline and issuing a single RAM access.
// LATENCY=0 is a combinational pass-through. Define DMEM_PERF_CNT_EN to add the stall and access counters.
module dmem_latency_ctrl #(
  parameter int LATENCY = 4,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic               CLK,
  input  logic               CLR,
  dmem_latency_ctrl_if.slave bus
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        access_cnt
`endif
);

  logic          req_w;
  logic          stall_w;
  logic [AW-3:0] word_addr_w;
  logic [DW-1:0] wdata_w;
  logic          unused_w;
`ifdef DMEM_PERF_CNT_EN
  logic          fire_w;
`endif

  assign req_w       = bus.MemReadM | bus.MemWriteM;
  assign word_addr_w = bus.ALUOutM[AW-1:2];
  assign wdata_w     = bus.WriteDataM;
  assign unused_w    = &{1'b0, bus.ALUOutM[1:0], req_w};
  assign bus.StallMem = stall_w;

  if (LATENCY == 0) begin : g_bypass
    // Outputs are forced low while CLR is asserted, matching the sequenced build.
    assign stall_w       = 1'b0;
    assign bus.ram_we    = CLR & bus.MemWriteM;
    assign bus.ram_addr  = CLR ? word_addr_w : '0;
    assign bus.ram_wdata = CLR ? wdata_w : '0;
    assign bus.ReadDataM = CLR ? bus.ram_rdata : '0;
`ifdef DMEM_PERF_CNT_EN
    assign fire_w = CLR & req_w;
`endif
  end else begin : g_seq
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-3:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          store_q, store_d;
    logic          we_w;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      store_d = store_q;
      rdata_d = rdata_q;
      stall_w = 1'b0;
      we_w    = 1'b0;
      case (state_q)
        IDLE: begin
          // The request cycle itself must stall, so this path is combinational.
          stall_w = req_w & CLR;
          if (req_w) begin
            addr_d  = word_addr_w;
            wdata_d = wdata_w;
            store_d = bus.MemWriteM;
            cnt_d   = CNT_LOAD;
            state_d = BUSY;
          end
        end
        BUSY: begin
          stall_w = 1'b1;
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            if (store_q) we_w = 1'b1;
            else         rdata_d = bus.ram_rdata;
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        addr_q  <= '0;
        wdata_q <= '0;
        store_q <= 1'b0;
        rdata_q <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        store_q <= store_d;
        rdata_q <= rdata_d;
      end
    end

    assign bus.ram_we    = we_w;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.ReadDataM = rdata_q;
`ifdef DMEM_PERF_CNT_EN
    assign fire_w = (state_q == BUSY) && (cnt_q == 4'd0);
`endif
  end

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] stall_cycles_q, access_cnt_q;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      stall_cycles_q <= '0;
      access_cnt_q   <= '0;
    end else begin
      if (stall_w && (stall_cycles_q != '1)) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (fire_w && (access_cnt_q != '1))    access_cnt_q   <= access_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign access_cnt   = access_cnt_q;
`endif

endmodule
